// File: rtl/fft_input_loader.sv
// Streams one 2048-point complex frame into four 512-word banks, then starts the FFT sequencer.
// Optional frame-length checking and zero padding: define FFT_LOADER_FRAME_CHECK_EN.
module fft_input_loader #(
  parameter int DATA_W   = 16,
  parameter int N_POINTS = 2048,
  parameter int ADDR_W   = 9
) (
  input  logic              iCLK,
  input  logic              iRESET,
  input  logic              iVALID,
  input  logic [DATA_W-1:0] iRE,
  input  logic [DATA_W-1:0] iIM,
  input  logic              iLAST,
  output logic              oREADY,
  output logic [3:0]        oWE_BANK,
  output logic [ADDR_W-1:0] oADDR_WR,
  output logic [DATA_W-1:0] oDATA_RE,
  output logic [DATA_W-1:0] oDATA_IM,
  output logic              oFFT_START,
  input  logic              iFFT_RDY,
  output logic              oBUSY,
  output logic              oFRAME_ERR
);

  localparam int CNT_W = ADDR_W + 2;

`ifdef FFT_LOADER_FRAME_CHECK_EN
  typedef enum logic [2:0] {IDLE, LOAD, START, WAIT_ACK, WAIT_DONE, FILL} state_t;
`else
  typedef enum logic [2:0] {IDLE, LOAD, START, WAIT_ACK, WAIT_DONE} state_t;
`endif

  state_t           state, next_state;
  logic [CNT_W-1:0] cnt;
  logic             last_cnt;
  logic             accept;
  logic             fill_wr;

  assign last_cnt = (cnt == CNT_W'(N_POINTS - 1));
  assign oREADY   = (state == LOAD);
  assign oBUSY    = (state != LOAD);

  always_ff @(posedge iCLK or posedge iRESET) begin
    if (iRESET) state <= IDLE;
    else        state <= next_state;
  end

  always_comb begin
    next_state = state;
    accept     = 1'b0;
    fill_wr    = 1'b0;
    case (state)
      IDLE:      if (iFFT_RDY) next_state = LOAD;
      LOAD: begin
        if (iVALID) begin
          accept = 1'b1;
          if (last_cnt) next_state = START;
`ifdef FFT_LOADER_FRAME_CHECK_EN
          else if (iLAST) next_state = FILL;
`endif
        end
      end
      START:     next_state = WAIT_ACK;
      WAIT_ACK:  if (!iFFT_RDY) next_state = WAIT_DONE;
      WAIT_DONE: if (iFFT_RDY) next_state = LOAD;
`ifdef FFT_LOADER_FRAME_CHECK_EN
      FILL: begin
        fill_wr = 1'b1;
        if (last_cnt) next_state = START;
      end
`endif
      default:   next_state = IDLE;
    endcase
  end

  // Bank select is the top two counter bits, so a radix-4 butterfly reads one word from each bank.
  always_ff @(posedge iCLK or posedge iRESET) begin
    if (iRESET) begin
      cnt        <= '0;
      oWE_BANK   <= '0;
      oADDR_WR   <= '0;
      oDATA_RE   <= '0;
      oDATA_IM   <= '0;
      oFFT_START <= 1'b0;
    end else begin
      oWE_BANK   <= '0;
      oFFT_START <= (state == START);
      if (accept || fill_wr) begin
        oWE_BANK <= 4'b0001 << cnt[CNT_W-1 -: 2];
        oADDR_WR <= cnt[ADDR_W-1:0];
        oDATA_RE <= fill_wr ? '0 : iRE;
        oDATA_IM <= fill_wr ? '0 : iIM;
        cnt      <= cnt + 1'b1;
      end
    end
  end

`ifdef FFT_LOADER_FRAME_CHECK_EN
  // An early marker or a missing marker on the final beat both flag the frame; only reset clears it.
  always_ff @(posedge iCLK or posedge iRESET) begin
    if (iRESET)                          oFRAME_ERR <= 1'b0;
    else if (accept && (iLAST != last_cnt)) oFRAME_ERR <= 1'b1;
  end
`else
  logic unused_last;
  assign unused_last = iLAST;
  assign oFRAME_ERR  = 1'b0;
`endif

endmodule

// File: doc/fft_input_loader.md
Name: fft_input_loader

Overview:
- Upstream neighbour of the FFT sequencer.
- Accepts a stream of complex samples over a valid/ready handshake and writes one 2048-point frame into the four 512-word data banks in natural order.
- Pulses the sequencer's start input, then holds off new input until the sequencer reports ready again.
- Sample n goes to bank n[10:9] at address n[8:0], so the first radix-4 stage reads x[n], x[n+512], x[n+1024] and x[n+1536] in parallel.

Parameters:
- DATA_W, 16, width of each real/imag sample component
- N_POINTS, 2048, frame length; fixed at 4 banks × 512 words
- ADDR_W, 9, per-bank address width (log2(N_POINTS/4))

Ports:
- iCLK  in  1  clock; all logic on rising edge
- iRESET  in  1  asynchronous, active-high reset
- iVALID  in  1  input sample valid
- iRE  in  DATA_W  sample real part
- iIM  in  DATA_W  sample imaginary part
- iLAST  in  1  end-of-frame marker; used only with the optional feature
- oREADY  out  1  loader accepts a sample this cycle
- oWE_BANK  out  4  one-hot bank write enable
- oADDR_WR  out  ADDR_W  bank write address
- oDATA_RE  out  DATA_W  write data, real
- oDATA_IM  out  DATA_W  write data, imaginary
- oFFT_START  out  1  one-cycle start pulse to the sequencer
- iFFT_RDY  in  1  sequencer ready/idle flag (high = idle)
- oBUSY  out  1  frame in flight (any state except LOAD)
- oFRAME_ERR  out  1  sticky framing error

Behaviour:
- Reset (async, iRESET=1), all outputs: oREADY=0, oWE_BANK=0, oADDR_WR=0, oDATA_*=0, oFFT_START=0, oBUSY=1, oFRAME_ERR=0; state=IDLE; sample counter=0.
- Reset asserted mid-frame discards the partial frame; no start is issued.
- States:
  - IDLE: iFFT_RDY=1 → LOAD.
  - LOAD:
    - oREADY=1 (combinational from state); handshake = iVALID & oREADY.
    - Each accepted beat registers bank=cnt[10:9], addr=cnt[8:0] and data onto the outputs the next cycle (latency 1).
    - oWE_BANK is high for exactly that one cycle, else 0.
    - cnt is 11 bits and increments per beat.
    - On the beat with cnt==2047: cnt wraps to 0, state → START.
  - START:
    - oREADY=0; last write is visible on the outputs this cycle.
    - oFFT_START=1 on the next cycle (registered); state → WAIT_ACK.
  - WAIT_ACK: waits for iFFT_RDY=0 → WAIT_DONE.
  - WAIT_DONE: waits for iFFT_RDY=1 → LOAD.
- Start timing: sample 2047 is accepted at cycle T, its write appears at T+1, and oFFT_START is high at T+2 only.
- Sample counter does not advance while iVALID=0; gaps are allowed anywhere in the frame.
- No input is accepted in IDLE, START, WAIT_ACK or WAIT_DONE. The upstream source must hold its data.
- oDATA_* hold their last value when oWE_BANK=0.

Optional Feature:
- Macro: FFT_LOADER_FRAME_CHECK_EN.
- With the macro defined:
  - iLAST is sampled on every accepted beat.
  - iLAST=1 with cnt<2047 (early end): the frame is zero-padded. The state enters FILL with oREADY=0 and writes zeros, one address per cycle, through cnt==2047, then proceeds to START. oFRAME_ERR is set.
  - Beat at cnt==2047 with iLAST=0 (late end): frame completes normally and oFRAME_ERR is set.
  - oFRAME_ERR is cleared only by reset.
- Without the macro: iLAST is ignored, FILL does not exist, and oFRAME_ERR is tied to 0.

Test Plan:
- Reset release with iFFT_RDY=1, then stream 2048 beats n=0..2047 (RE=n, IM=~n) continuously → writes to bank 0 addr 0 through bank 3 addr 511, data matching; a single oFFT_START pulse 2 cycles after the last handshake; oREADY=0 from then on.
- Same frame with iVALID toggled 1/0 → identical write sequence; each oWE_BANK pulse one cycle after its handshake; start is issued only after beat 2047.
- After start, model the sequencer: iFFT_RDY falls 1 cycle after start and rises 3000 cycles later → oREADY stays 0 throughout, returns to 1 on the cycle after iFFT_RDY rises; second frame loads correctly.
- Assert iRESET at beat 1000 → all outputs reach reset values immediately with no start pulse; after release a full new frame loads from bank 0 addr 0.
- FRAME_CHECK_EN with iLAST on beat 99 → addresses 100..2047 are written with zeros at one per cycle, oFRAME_ERR=1, then start is issued.
- FRAME_CHECK_EN with iLAST never asserted → oFRAME_ERR=1 after beat 2047; start is still issued.
